nabp_angle_scheduler: RTL and testbench

- Iteration sequencer that drives the swap-control side of the NABP state control.
- Steps through every projection angle and fetches the per-angle accumulator bases from an external angle LUT. It presents them to the state control with the next-iteration acknowledge, then grants buffer swaps.
- Toggles the double-buffer bank select on each granted swap, gated on the PE array having released the other bank.
- Reports completion after the last angle's shift phase finishes.

---
 rtl/nabp_angle_scheduler_pkg.sv | 45 ++++
 rtl/nabp_angle_counter.sv | 50 +++++
 rtl/nabp_angle_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_nabp_angle_scheduler.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_angle_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// nabp_angle_scheduler_pkg
// Shared definitions for the NABP angle scheduler:
//   - FSM state encoding of the scheduler
//   - default widths of the three LUT word fields
//   - field offsets of the packed LUT word {sh_base, mp_init, mp_base}
//     (sh_base in the MSBs, mp_base in the LSBs)
//   - width of the optional stall counter (NABP_SCHED_PERF_EN builds)
// -----------------------------------------------------------------------------
package nabp_angle_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_WAIT_ITR  = 3'd3,
    ST_WAIT_SWAP = 3'd4,
    ST_DRAIN     = 3'd5
  } sched_state_e;

  // Default field widths of a LUT word.
  localparam int DEF_SH_W = 10;
  localparam int DEF_MI_W = 12;
  localparam int DEF_MB_W = 12;

  // Stall counter width used when NABP_SCHED_PERF_EN is defined.
  localparam int STALL_W = 32;

  // Packing order is {sh, mi, mb}: mb sits at bit 0, mi directly above it,
  // sh on top.
  localparam int LUT_MB_LSB = 0;

  function automatic int lut_mi_lsb(input int mb_w);
    return mb_w;
  endfunction

  function automatic int lut_sh_lsb(input int mi_w, input int mb_w);
    return mi_w + mb_w;
  endfunction

  function automatic int lut_word_w(input int sh_w, input int mi_w, input int mb_w);
    return sh_w + mi_w + mb_w;
  endfunction

endpackage

// File: rtl/nabp_angle_counter.sv
// -----------------------------------------------------------------------------
// nabp_angle_counter
// Projection-angle counter for the scheduler. Counts 0..NUM_ANGLES-1 and
// never wraps: an increment at the last angle holds the value, so the count
// can never address past the end of the angle LUT.
// Ports:
//   clk, reset  clock / asynchronous active-high reset (count -> 0)
//   clr         synchronous clear to 0 (wins over inc)
//   inc         advance by one unless already at the last angle
//   angle       registered current angle
//   is_last     angle == NUM_ANGLES-1
// -----------------------------------------------------------------------------
module nabp_angle_counter #(
  parameter int NUM_ANGLES = 180,
  parameter int ANGLE_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [ANGLE_W-1:0] angle,
  output logic               is_last
);

  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(NUM_ANGLES - 1);

  logic [ANGLE_W-1:0] angle_q;
  logic [ANGLE_W-1:0] angle_d;

  always_comb begin
    angle_d = angle_q;
    if (clr) begin
      angle_d = '0;
    end else if (inc && (angle_q != LAST_ANGLE)) begin
      angle_d = angle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle_q <= '0;
    end else begin
      angle_q <= angle_d;
    end
  end

  assign angle   = angle_q;
  assign is_last = (angle_q == LAST_ANGLE);

endmodule

// File: rtl/nabp_angle_scheduler.sv
// -----------------------------------------------------------------------------
// nabp_angle_scheduler
// Iteration sequencer for the swap-control side of the NABP state control.
// For every projection angle it reads the accumulator bases from the angle
// LUT, presents them with the next-iteration acknowledge, then grants the
// buffer swap (toggling the double-buffer bank) once the PE array has freed
// the other bank. After the last angle's shift phase it pulses done.
//
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   start             frame start pulse (honoured in IDLE only)
//   abort             synchronous abort back to IDLE, highest priority
//   lut_rd, lut_addr  LUT read strobe and angle address
//   lut_data          LUT word {sh_base, mp_init, mp_base}, valid 1 cycle
//                     after lut_rd
//   sw_next_itr       state control ready for a new iteration (level)
//   sw_swap           state control requests a buffer swap (level)
//   pe_bank_free      PE array has released the non-active bank (level)
//   sw_next_itr_ack   one-cycle next-iteration acknowledge
//   sw_swap_ack       one-cycle swap grant
//   sw_sh_accu_base, sw_mp_accu_init, sw_mp_accu_base
//                     accumulator values for the current angle
//   bank_sel          active buffer bank
//   busy              high whenever the FSM is not IDLE
//   done              one-cycle end-of-frame pulse
//   stall_cycles      (NABP_SCHED_PERF_EN only) cycles spent waiting for
//                     pe_bank_free while a swap is requested
//
// Build option: define NABP_SCHED_PERF_EN to add the stall_cycles counter.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module nabp_angle_scheduler
  import nabp_angle_scheduler_pkg::*;
#(
  parameter int NUM_ANGLES = 180,   // >= 1
  parameter int ANGLE_W    = 8,     // 2**ANGLE_W >= NUM_ANGLES
  parameter int SH_W       = DEF_SH_W,
  parameter int MI_W       = DEF_MI_W,
  parameter int MB_W       = DEF_MB_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic                        lut_rd,
  output logic [ANGLE_W-1:0]          lut_addr,
  input  logic [SH_W+MI_W+MB_W-1:0]   lut_data,
  input  logic                        sw_next_itr,
  input  logic                        sw_swap,
  input  logic                        pe_bank_free,
  output logic                        sw_next_itr_ack,
  output logic                        sw_swap_ack,
  output logic [SH_W-1:0]             sw_sh_accu_base,
  output logic [MI_W-1:0]             sw_mp_accu_init,
  output logic [MB_W-1:0]             sw_mp_accu_base,
  output logic                        bank_sel,
  output logic                        busy,
`ifdef NABP_SCHED_PERF_EN
  output logic [STALL_W-1:0]          stall_cycles,
`endif
  output logic                        done
);

  localparam int MB_LSB = LUT_MB_LSB;
  localparam int MI_LSB = lut_mi_lsb(MB_W);
  localparam int SH_LSB = lut_sh_lsb(MI_W, MB_W);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  sched_state_e state_q, state_d;

  logic               lut_rd_q,      lut_rd_d;
  logic               itr_ack_q,     itr_ack_d;
  logic               swap_ack_q,    swap_ack_d;
  logic [SH_W-1:0]    sh_base_q,     sh_base_d;
  logic [MI_W-1:0]    mp_init_q,     mp_init_d;
  logic [MB_W-1:0]    mp_base_q,     mp_base_d;
  logic               bank_sel_q,    bank_sel_d;
  logic               busy_q,        busy_d;
  logic               done_q,        done_d;

  logic [ANGLE_W-1:0] angle;
  logic               angle_last;
  logic               cnt_clr;
  logic               cnt_inc;

  logic               start_accept;
  logic               swap_grant;
  logic               drain_done;

  // Qualified events, all suppressed by abort so it can override any state.
  assign start_accept = !abort && (state_q == ST_IDLE)      && start;
  assign swap_grant   = !abort && (state_q == ST_WAIT_SWAP) && sw_swap && pe_bank_free;
  assign drain_done   = !abort && (state_q == ST_DRAIN)     && sw_next_itr;

  // ---------------------------------------------------------------------------
  // Angle counter: cleared at frame start, at frame end and on abort;
  // advanced by each granted swap.
  // ---------------------------------------------------------------------------
  assign cnt_clr = abort || start_accept || drain_done;
  assign cnt_inc = swap_grant;

  nabp_angle_counter #(
    .NUM_ANGLES (NUM_ANGLES),
    .ANGLE_W    (ANGLE_W)
  ) u_angle_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .angle   (angle),
    .is_last (angle_last)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // Leaving WAIT_ITR / WAIT_SWAP as soon as the request is taken is what keeps
  // a level request that stays high from being acknowledged twice.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          state_d = ST_WAIT_ITR;
        end
        ST_WAIT_ITR: begin
          if (sw_next_itr) begin
            state_d = ST_WAIT_SWAP;
          end
        end
        ST_WAIT_SWAP: begin
          // The angle checked here is the pre-increment one; the next
          // angle's fetch overlaps the shift phase of the current one.
          if (sw_swap && pe_bank_free) begin
            state_d = angle_last ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (sw_next_itr) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the output flops)
  // ---------------------------------------------------------------------------
  always_comb begin
    lut_rd_d   = (state_d == ST_FETCH);
    itr_ack_d  = !abort && (state_q == ST_WAIT_ITR) && sw_next_itr;
    swap_ack_d = swap_grant;
    bank_sel_d = bank_sel_q ^ swap_grant;
    busy_d     = (state_d != ST_IDLE);
    done_d     = drain_done;

    // Accumulator values are only loaded at the end of LATCH, i.e. the cycle
    // in which the LUT answers the read issued in FETCH. They then hold until
    // the next LATCH, covering the whole ack window.
    sh_base_d  = sh_base_q;
    mp_init_d  = mp_init_q;
    mp_base_d  = mp_base_q;
    if (!abort && (state_q == ST_LATCH)) begin
      sh_base_d = lut_data[SH_LSB +: SH_W];
      mp_init_d = lut_data[MI_LSB +: MI_W];
      mp_base_d = lut_data[MB_LSB +: MB_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_rd_q   <= 1'b0;
      itr_ack_q  <= 1'b0;
      swap_ack_q <= 1'b0;
      sh_base_q  <= '0;
      mp_init_q  <= '0;
      mp_base_q  <= '0;
      bank_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      lut_rd_q   <= lut_rd_d;
      itr_ack_q  <= itr_ack_d;
      swap_ack_q <= swap_ack_d;
      sh_base_q  <= sh_base_d;
      mp_init_q  <= mp_init_d;
      mp_base_q  <= mp_base_d;
      bank_sel_q <= bank_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The counter register doubles as the LUT address register.
  assign lut_addr        = angle;
  assign lut_rd          = lut_rd_q;
  assign sw_next_itr_ack = itr_ack_q;
  assign sw_swap_ack     = swap_ack_q;
  assign sw_sh_accu_base = sh_base_q;
  assign sw_mp_accu_init = mp_init_q;
  assign sw_mp_accu_base = mp_base_q;
  assign bank_sel        = bank_sel_q;
  assign busy            = busy_q;
  assign done            = done_q;

  // ---------------------------------------------------------------------------
  // Optional swap-stall counter. Cleared only by an accepted start and
  // deliberately left alone by abort so an aborted frame can be inspected.
  // ---------------------------------------------------------------------------
`ifdef NABP_SCHED_PERF_EN
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               swap_stall;

  assign swap_stall = (state_q == ST_WAIT_SWAP) && sw_swap && !pe_bank_free;

  always_comb begin
    stall_d = stall_q;
    if (start_accept) begin
      stall_d = '0;
    end else if (swap_stall && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_nabp_angle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nabp_angle_scheduler
// Scoreboard bench for nabp_angle_scheduler. A driver plays the state control
// and the PE array; for each frame it pushes the expected LUT addresses and
// the expected ack / swap / done sequence (taken from the LUT contents) into
// queues. A monitor on the falling edge pops and compares whenever the DUT
// pulses. A second instance with NUM_ANGLES=1 covers the single-angle case.
// Define NABP_SCHED_PERF_EN to also check stall_cycles.
// -----------------------------------------------------------------------------
module tb_nabp_angle_scheduler;
  import nabp_angle_scheduler_pkg::*;

  localparam int N    = 3;
  localparam int AW   = 8;
  localparam int SH_W = 10;
  localparam int MI_W = 12;
  localparam int MB_W = 12;
  localparam int LW   = SH_W + MI_W + MB_W;

  localparam int EV_ITR  = 0;
  localparam int EV_SWAP = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int            kind;
    logic [LW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (NUM_ANGLES = 3)
  logic            reset, start, abort;
  logic            lut_rd;
  logic [AW-1:0]   lut_addr;
  logic [LW-1:0]   lut_data;
  logic            sw_next_itr, sw_swap, pe_bank_free;
  logic            sw_next_itr_ack, sw_swap_ack;
  logic [SH_W-1:0] sw_sh_accu_base;
  logic [MI_W-1:0] sw_mp_accu_init;
  logic [MB_W-1:0] sw_mp_accu_base;
  logic            bank_sel, busy, done;

  // Single-angle instance
  logic            u1_start, u1_abort, u1_lut_rd;
  logic [AW-1:0]   u1_lut_addr;
  logic [LW-1:0]   u1_lut_data;
  logic            u1_next, u1_swap, u1_free;
  logic            u1_ack, u1_swap_ack;
  logic [SH_W-1:0] u1_sh;
  logic [MI_W-1:0] u1_mi;
  logic [MB_W-1:0] u1_mb;
  logic            u1_bank, u1_busy, u1_done;

`ifdef NABP_SCHED_PERF_EN
  logic [31:0] stall_cycles, u1_stall_cycles;
`endif

  nabp_angle_scheduler #(
    .NUM_ANGLES(N), .ANGLE_W(AW), .SH_W(SH_W), .MI_W(MI_W), .MB_W(MB_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lut_rd(lut_rd), .lut_addr(lut_addr), .lut_data(lut_data),
    .sw_next_itr(sw_next_itr), .sw_swap(sw_swap), .pe_bank_free(pe_bank_free),
    .sw_next_itr_ack(sw_next_itr_ack), .sw_swap_ack(sw_swap_ack),
    .sw_sh_accu_base(sw_sh_accu_base), .sw_mp_accu_init(sw_mp_accu_init),
    .sw_mp_accu_base(sw_mp_accu_base), .bank_sel(bank_sel), .busy(busy),
`ifdef NABP_SCHED_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  nabp_angle_scheduler #(
    .NUM_ANGLES(1), .ANGLE_W(AW), .SH_W(SH_W), .MI_W(MI_W), .MB_W(MB_W)
  ) dut1 (
    .clk(clk), .reset(reset), .start(u1_start), .abort(u1_abort),
    .lut_rd(u1_lut_rd), .lut_addr(u1_lut_addr), .lut_data(u1_lut_data),
    .sw_next_itr(u1_next), .sw_swap(u1_swap), .pe_bank_free(u1_free),
    .sw_next_itr_ack(u1_ack), .sw_swap_ack(u1_swap_ack),
    .sw_sh_accu_base(u1_sh), .sw_mp_accu_init(u1_mi),
    .sw_mp_accu_base(u1_mb), .bank_sel(u1_bank), .busy(u1_busy),
`ifdef NABP_SCHED_PERF_EN
    .stall_cycles(u1_stall_cycles),
`endif
    .done(u1_done)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  logic [LW-1:0] lut_mem [N];
  ev_t           ev_q[$];
  int            addr_q[$];
  logic          bank_model    = 1'b0;
  logic [LW-1:0] last_itr_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [LW-1:0] pack(input logic [SH_W-1:0] sh,
                                         input logic [MI_W-1:0] mi,
                                         input logic [MB_W-1:0] mb);
    return {sh, mi, mb};
  endfunction

  function automatic logic [63:0] main_outs();
    return 64'({lut_rd, lut_addr, sw_next_itr_ack, sw_swap_ack, sw_sh_accu_base,
                sw_mp_accu_init, sw_mp_accu_base, bank_sel, busy, done});
  endfunction

  function automatic logic [63:0] u1_outs();
    return 64'({u1_lut_rd, u1_lut_addr, u1_ack, u1_swap_ack, u1_sh, u1_mi, u1_mb,
                u1_bank, u1_busy, u1_done});
  endfunction

  task automatic default_lut();
    for (int k = 0; k < N; k++) begin
      lut_mem[k] = pack(SH_W'(k + 1), MI_W'(10 * k), MB_W'(20 * k));
    end
  endtask

  task automatic random_lut();
    for (int k = 0; k < N; k++) begin
      lut_mem[k] = pack(SH_W'($urandom), MI_W'($urandom), MB_W'($urandom));
    end
  endtask

  // LUT responder: data valid the cycle after a read, junk otherwise.
  initial begin
    logic [AW-1:0] a;
    logic          rd;
    logic [63:0]   junk;
    lut_data = '0;
    forever begin
      @(posedge clk);
      rd = lut_rd;
      a  = lut_addr;
      #1;
      if (rd) begin
        lut_data = (int'(a) < N) ? lut_mem[a] : '0;
      end else begin
        junk     = {$urandom, $urandom};
        lut_data = junk[LW-1:0];
      end
    end
  end

  // Monitor
  task automatic mon_event(input int kind, input logic [LW-1:0] payload);
    ev_t e;
    if (ev_q.size() == 0) begin
      fail_now("unexpected_pulse", $sformatf("got event kind %0d, expected none", kind));
    end else begin
      e = ev_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (e.kind == EV_ITR && kind == EV_ITR) begin
        chk("itr_payload", 64'(payload), 64'(e.data));
        last_itr_data = e.data;
      end
      if (kind == EV_SWAP) begin
        bank_model = ~bank_model;
        chk("bank_sel", 64'(bank_sel), 64'(bank_model));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bank_model = 1'b0;
    end else begin
      if (lut_rd) begin
        if (addr_q.size() == 0) begin
          fail_now("lut_rd_unexpected", $sformatf("got read of addr %0d, expected no read", lut_addr));
        end else begin
          chk("lut_addr", 64'(lut_addr), 64'(addr_q.pop_front()));
        end
      end
      if (sw_next_itr_ack) mon_event(EV_ITR, {sw_sh_accu_base, sw_mp_accu_init, sw_mp_accu_base});
      if (sw_swap_ack)     mon_event(EV_SWAP, '0);
      if (done)            mon_event(EV_DONE, '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name, input int which, input int budget);
    bit seen = 1'b0;
    int n    = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      case (which)
        0:       seen = sw_next_itr_ack;
        1:       seen = sw_swap_ack;
        default: seen = done;
      endcase
    end
    if (!seen) fail_now({"timeout_", name}, $sformatf("got no pulse in %0d cycles, expected one", budget));
  endtask

  // One frame of the state-control / PE-array model.
  task automatic run_frame(input int dly, input bit hold, input int stall_angle,
                           input int stall_n, input int abort_angle);
    bit aborted = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr_q.push_back(k);
      ev_q.push_back('{kind: EV_ITR, data: lut_mem[k]});
      ev_q.push_back('{kind: EV_SWAP, data: '0});
    end
    ev_q.push_back('{kind: EV_DONE, data: '0});

    if (hold) sw_next_itr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int k = 0; k < N && !aborted; k++) begin
      if (!hold) begin
        repeat (dly) tick();
        sw_next_itr = 1'b1;
      end
      wait_pulse("itr_ack", 0, 40);
      if (!hold) sw_next_itr = 1'b0;
      repeat (dly) tick();
      sw_swap = 1'b1;
      if (k == abort_angle) begin
        pe_bank_free = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort        = 1'b0;
        sw_swap      = 1'b0;
        pe_bank_free = 1'b1;
        sw_next_itr  = 1'b0;
        chk("busy_after_abort", 64'(busy), 64'd0);
        chk("pulses_after_abort", 64'({lut_rd, sw_next_itr_ack, sw_swap_ack, done}), 64'd0);
        chk("sw_held_after_abort",
            64'({sw_sh_accu_base, sw_mp_accu_init, sw_mp_accu_base}), 64'(last_itr_data));
        ev_q.delete();
        addr_q.delete();
        repeat (6) tick();
        chk("idle_after_abort", 64'(busy), 64'd0);
        aborted = 1'b1;
      end else if (k == stall_angle) begin
        pe_bank_free = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          start = (s == 2);     // stray start mid-frame must be ignored
          tick();
          start = 1'b0;
          chk("no_swap_ack_in_stall", 64'(sw_swap_ack), 64'd0);
        end
        pe_bank_free = 1'b1;
        tick();
        chk("swap_ack_after_free", 64'(sw_swap_ack), 64'd1);
        sw_swap = 1'b0;
      end else begin
        wait_pulse("swap_ack", 1, 40);
        sw_swap = 1'b0;
      end
    end

    if (!aborted) begin
      if (!hold) begin
        repeat (dly) tick();
        sw_next_itr = 1'b1;
      end
      wait_pulse("done", 2, 40);
      chk("busy_at_done", 64'(busy), 64'd0);
      sw_next_itr = 1'b0;
      tick();
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("scoreboard_drained", 64'(ev_q.size()), 64'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    sw_next_itr  = 1'b0;
    sw_swap      = 1'b0;
    pe_bank_free = 1'b1;
    u1_start     = 1'b0;
    u1_abort     = 1'b0;
    u1_next      = 1'b0;
    u1_swap      = 1'b0;
    u1_free      = 1'b1;
    u1_lut_data  = pack(SH_W'(5), MI_W'(6), MB_W'(7));
    default_lut();

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", main_outs(), 64'd0);
    chk("reset_u1_outputs", u1_outs(), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 64'(busy), 64'd0);

    // Frame with the reference LUT: acks (1,0,0),(2,10,20),(3,20,40)
    run_frame(2, 1'b0, -1, 0, -1);

    // Seven-cycle bank stall on angle 0
    random_lut();
    run_frame(1, 1'b0, 0, 7, -1);
`ifdef NABP_SCHED_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'd7);
`endif

    // sw_next_itr held high for the whole frame
    random_lut();
    run_frame(int'($urandom_range(0, 3)), 1'b1, -1, 0, -1);

    // Abort while waiting for the swap at angle 1, then a clean restart
    random_lut();
    run_frame(2, 1'b0, -1, 0, 1);
    run_frame(0, 1'b0, -1, 0, -1);

    // Randomised frames
    for (int i = 0; i < 4; i++) begin
      random_lut();
      run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, N)), int'($urandom_range(1, 4)), -1);
    end

    // Asynchronous reset in the middle of a frame
    default_lut();
    ev_q.delete();
    addr_q.delete();
    addr_q.push_back(0);
    ev_q.push_back('{kind: EV_ITR, data: lut_mem[0]});
    sw_next_itr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pulse("itr_ack_pre_reset", 0, 40);
    sw_next_itr = 1'b0;
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", main_outs(), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    ev_q.delete();
    addr_q.delete();
    tick();
    chk("idle_after_async_reset", 64'(busy), 64'd0);

    // NUM_ANGLES=1: start together with abort is dropped
    u1_start = 1'b1;
    u1_abort = 1'b1;
    tick();
    u1_start = 1'b0;
    u1_abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("u1_start_abort_idle", 64'({u1_busy, u1_lut_rd}), 64'd0);
      tick();
    end

    // NUM_ANGLES=1: lone start with all requests already high
    u1_next  = 1'b1;
    u1_swap  = 1'b1;
    u1_free  = 1'b1;
    u1_start = 1'b1;
    tick();
    u1_start = 1'b0;
    chk("u1_fetch", 64'({u1_busy, u1_lut_rd, u1_lut_addr}), 64'({1'b1, 1'b1, 8'd0}));
    tick();
    chk("u1_latch", 64'({u1_busy, u1_lut_rd, u1_ack}), 64'({1'b1, 1'b0, 1'b0}));
    tick();
    chk("u1_wait_itr_no_ack", 64'(u1_ack), 64'd0);
    tick();
    chk("u1_ack_latency4", 64'(u1_ack), 64'd1);
    chk("u1_payload", 64'({u1_sh, u1_mi, u1_mb}), 64'(pack(SH_W'(5), MI_W'(6), MB_W'(7))));
    tick();
    chk("u1_swap_ack", 64'({u1_ack, u1_swap_ack, u1_bank}), 64'({1'b0, 1'b1, 1'b1}));
    tick();
    chk("u1_done", 64'({u1_done, u1_busy, u1_swap_ack}), 64'({1'b1, 1'b0, 1'b0}));
    tick();
    chk("u1_idle_after_done", 64'({u1_done, u1_busy, u1_lut_rd}), 64'd0);
    u1_next = 1'b0;
    u1_swap = 1'b0;

    repeat (3) tick();
    chk("scoreboard_empty_at_end", 64'(ev_q.size() + addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
